// File: rtl/bt_lc_pkg.sv
// Shared link-controller definitions: inquiry-response FSM states, LFSR seed and backoff bounds.
// The EIR_TX state exists only when IR_EXT_INQ_RSP_EN is defined.
package bt_lc_pkg;

  typedef enum logic [2:0] {
    IR_IDLE      = 3'd0,
    IR_SCAN1     = 3'd1,
    IR_BACKOFF   = 3'd2,
    IR_SCAN2     = 3'd3,
    IR_RESP_WAIT = 3'd4,
`ifdef IR_EXT_INQ_RSP_EN
    IR_FHS_TX    = 3'd5,
    IR_EIR_TX    = 3'd6
`else
    IR_FHS_TX    = 3'd5
`endif
  } ir_state_e;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam int          BACKOFF_MAX       = 1023;
  localparam int          BACKOFF_W         = $clog2(BACKOFF_MAX + 1);
  localparam logic [7:0]  RESP_CNT_MAX      = 8'hFF;

  // Fibonacci step for x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5, shift right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

endpackage

// File: rtl/ir_backoff_lfsr.sv
// 16-bit free-running backoff LFSR with synchronous seed load; a zero seed maps to the default
// so the register can never lock up in the all-zero state.
module ir_backoff_lfsr
  import bt_lc_pkg::*;
(
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        i_load,
  input  logic        i_en,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_state <= LFSR_DEFAULT_SEED;
    end else if (i_load) begin
      r_state <= (i_seed == 16'h0000) ? LFSR_DEFAULT_SEED : i_seed;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/ir_ctrl.sv
// Inquiry-scan response controller: scan, random backoff, second scan, FHS response.
// Define IR_EXT_INQ_RSP_EN to append an extended inquiry response (EIR) stage after FHS.
module ir_ctrl
  import bt_lc_pkg::*;
(
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        tslot_p,
  input  logic        regi_InquiryScanEnable,
  input  logic        InquiryScanWindow,
  input  logic        rx_id_p,
  input  logic [15:0] regi_backoff_seed,
  input  logic        fhs_tx_done_p,
  output logic        corr_en,
  output logic        fhs_tx_req,
  output logic        backoff_active,
  output logic [2:0]  ir_state,
`ifdef IR_EXT_INQ_RSP_EN
  input  logic        eir_tx_done_p,
  output logic        eir_tx_req,
`endif
  output logic [7:0]  resp_cnt
);

  ir_state_e             r_state;
  ir_state_e             w_state_nxt;
  logic [BACKOFF_W-1:0]  r_backoff_cnt;
  logic [BACKOFF_W-1:0]  w_backoff_nxt;
  logic [7:0]            r_resp_cnt;
  logic [7:0]            w_resp_nxt;
  logic [15:0]           w_lfsr;
  logic                  w_lfsr_load;
  logic                  w_id_hit;
  logic                  w_unused_lfsr_hi;
`ifdef IR_EXT_INQ_RSP_EN
  logic                  r_eir_armed;
  logic                  w_eir_armed_nxt;
`endif

  // Reseed exactly when scanning starts so each scan session begins from a known sequence.
  assign w_lfsr_load = (r_state == IR_IDLE) & regi_InquiryScanEnable;

  ir_backoff_lfsr u_lfsr (
    .clk_6M  (clk_6M),
    .rstz    (rstz),
    .i_load  (w_lfsr_load),
    .i_en    (1'b1),
    .i_seed  (regi_backoff_seed),
    .o_state (w_lfsr)
  );

  // Only the low bits select the backoff; the rest of the LFSR is intentionally unused.
  assign w_unused_lfsr_hi = ^w_lfsr[15:BACKOFF_W];

  assign corr_en        = InquiryScanWindow &
                          ((r_state == IR_SCAN1) | (r_state == IR_SCAN2));
  assign w_id_hit       = rx_id_p & corr_en;
  assign fhs_tx_req     = (r_state == IR_FHS_TX);
  assign backoff_active = (r_state == IR_BACKOFF);
  assign ir_state       = r_state;
  assign resp_cnt       = r_resp_cnt;
`ifdef IR_EXT_INQ_RSP_EN
  assign eir_tx_req     = (r_state == IR_EIR_TX) & r_eir_armed;
`endif

  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_backoff_nxt = r_backoff_cnt;
    w_resp_nxt    = r_resp_cnt;
`ifdef IR_EXT_INQ_RSP_EN
    w_eir_armed_nxt = r_eir_armed;
`endif
    if (!regi_InquiryScanEnable) begin
      w_state_nxt   = IR_IDLE;
      w_backoff_nxt = '0;
`ifdef IR_EXT_INQ_RSP_EN
      w_eir_armed_nxt = 1'b0;
`endif
    end else begin
      case (r_state)
        IR_IDLE: w_state_nxt = IR_SCAN1;
        IR_SCAN1: begin
          if (w_id_hit) begin
            w_state_nxt   = IR_BACKOFF;
            w_backoff_nxt = w_lfsr[BACKOFF_W-1:0];
          end
        end
        // A count of N leaves on the (N+1)-th slot boundary.
        IR_BACKOFF: begin
          if (tslot_p) begin
            if (r_backoff_cnt == '0) begin
              w_state_nxt = IR_SCAN2;
            end else begin
              w_backoff_nxt = r_backoff_cnt - BACKOFF_W'(1);
            end
          end
        end
        IR_SCAN2: begin
          if (w_id_hit) begin
            w_state_nxt = IR_RESP_WAIT;
          end
        end
        IR_RESP_WAIT: begin
          if (tslot_p) begin
            w_state_nxt = IR_FHS_TX;
          end
        end
        IR_FHS_TX: begin
          if (fhs_tx_done_p) begin
            w_resp_nxt = (r_resp_cnt == RESP_CNT_MAX) ? r_resp_cnt : r_resp_cnt + 8'd1;
`ifdef IR_EXT_INQ_RSP_EN
            w_state_nxt     = IR_EIR_TX;
            w_eir_armed_nxt = 1'b0;
`else
            w_state_nxt = IR_SCAN1;
`endif
          end
        end
`ifdef IR_EXT_INQ_RSP_EN
        IR_EIR_TX: begin
          if (!r_eir_armed) begin
            if (tslot_p) begin
              w_eir_armed_nxt = 1'b1;
            end
          end else if (eir_tx_done_p) begin
            w_state_nxt     = IR_SCAN1;
            w_eir_armed_nxt = 1'b0;
          end
        end
`endif
        default: w_state_nxt = IR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      r_state       <= IR_IDLE;
      r_backoff_cnt <= '0;
      r_resp_cnt    <= '0;
`ifdef IR_EXT_INQ_RSP_EN
      r_eir_armed   <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_backoff_cnt <= w_backoff_nxt;
      r_resp_cnt    <= w_resp_nxt;
`ifdef IR_EXT_INQ_RSP_EN
      r_eir_armed   <= w_eir_armed_nxt;
`endif
    end
  end

endmodule
